// File: rtl/ula_pkg.sv
// Shared types and helpers for the sequential AES datapath ALU.
// The counter field is stored with its most significant byte in byte 0 (bits [7:0]).
package ula_pkg;

  localparam int DATA_W_DEF    = 128;
  localparam int CTR_BYTES_DEF = 8;
  // Widest counter field the byte-reverse helper can handle, in bits
  localparam int CTR_MAX_W     = 1024;

  typedef enum logic [2:0] {
    OP_XOR = 3'b000,
    OP_INC = 3'b001,
    OP_MOV = 3'b010,
    OP_LDC = 3'b011,
    OP_NXT = 3'b100
  } ula_op_e;

  // Reverse the order of the low nBytes bytes; converts between bus order and numeric order
  function automatic logic [CTR_MAX_W-1:0] byteRev(input logic [CTR_MAX_W-1:0] v,
                                                   input int nBytes);
    logic [CTR_MAX_W-1:0] r;
    r = '0;
    for (int k = 0; k < CTR_MAX_W / 8; k++) begin
      if (k < nBytes) begin
        r[8*(nBytes-1-k) +: 8] = v[8*k +: 8];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ula_ctr_add.sv
// Combinational counter-field adder: adds an 8-bit amount to the byte-reversed
// counter field of a block, reporting the carry-out; bytes above the field pass through.
module ula_ctr_add
  import ula_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int CTR_BYTES = CTR_BYTES_DEF
) (
  input  logic [DATA_W-1:0] data_i,
  input  logic [7:0]        amount_i,
  output logic [DATA_W-1:0] sum_o,
  output logic              carry_o
);

  localparam int CW = 8 * CTR_BYTES;

  logic [CW-1:0] fieldVal;
  logic [CW:0]   total;

  always_comb begin
    fieldVal = CW'(byteRev(CTR_MAX_W'(data_i[CW-1:0]), CTR_BYTES));
    total    = {1'b0, fieldVal} + (CW+1)'(amount_i);
    sum_o    = data_i;
    sum_o[CW-1:0] = CW'(byteRev(CTR_MAX_W'(total[CW-1:0]), CTR_BYTES));
    carry_o  = total[CW];
  end

endmodule

// File: rtl/ula_seq.sv
// Registered AES datapath ALU with an internal CTR-mode counter and a
// one-stage valid/ready output register.
module ula_seq
  import ula_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int CTR_BYTES = CTR_BYTES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        fs,
  input  logic [DATA_W-1:0] bus_a,
  input  logic [DATA_W-1:0] bus_b,
  input  logic [7:0]        step,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] bus_ula,
  output logic              ovf
);

  logic [DATA_W-1:0] ctr_q, ctr_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              ovf_q, ovf_d;
  logic              outValid_q, outValid_d;

  logic [DATA_W-1:0] incSum, nxtSum;
  logic              incCarry, nxtCarry;
  logic [DATA_W-1:0] opResult, opCtr;
  logic              opOvf;
  logic              accept;

  ula_ctr_add #(.DATA_W(DATA_W), .CTR_BYTES(CTR_BYTES)) uIncAdd (
    .data_i  (bus_a),
    .amount_i(step),
    .sum_o   (incSum),
    .carry_o (incCarry)
  );

  ula_ctr_add #(.DATA_W(DATA_W), .CTR_BYTES(CTR_BYTES)) uNxtAdd (
    .data_i  (ctr_q),
    .amount_i(8'd1),
    .sum_o   (nxtSum),
    .carry_o (nxtCarry)
  );

  assign in_ready  = !outValid_q || out_ready;
  assign accept    = in_valid && in_ready;
  assign out_valid = outValid_q;
  assign bus_ula   = result_q;
  assign ovf       = ovf_q;

  // Operation decode; unused encodings behave as MOV
  always_comb begin
    opResult = bus_a;
    opOvf    = 1'b0;
    opCtr    = ctr_q;
    case (fs)
      OP_XOR: opResult = bus_a ^ bus_b;
      OP_INC: begin
        opResult = incSum;
        opOvf    = incCarry;
      end
      OP_LDC: opCtr = bus_a;
      OP_NXT: begin
        opResult = ctr_q;
        opOvf    = nxtCarry;
        opCtr    = nxtSum;
      end
      default: ;
    endcase
  end

  // A held result keeps everything frozen, including the counter
  always_comb begin
    outValid_d = outValid_q;
    result_d   = result_q;
    ovf_d      = ovf_q;
    ctr_d      = ctr_q;
    if (accept) begin
      outValid_d = 1'b1;
      result_d   = opResult;
      ovf_d      = opOvf;
      ctr_d      = opCtr;
    end else if (out_ready) begin
      outValid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      outValid_q <= 1'b0;
      result_q   <= '0;
      ovf_q      <= 1'b0;
      ctr_q      <= '0;
    end else begin
      outValid_q <= outValid_d;
      result_q   <= result_d;
      ovf_q      <= ovf_d;
      ctr_q      <= ctr_d;
    end
  end

endmodule

// File: tb/tb_ula_seq.sv
// Self-checking bench for ula_seq: constant vector table, directed counter
// sequences, and randomized traffic checked against a transaction-level model.
module tb_ula_seq;

  localparam int DW = 128;
  localparam int CB = 8;
  localparam int CW = 8 * CB;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    fs;
  logic [DW-1:0] bus_a;
  logic [DW-1:0] bus_b;
  logic [7:0]    step;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] bus_ula;
  logic          ovf;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic          expValid;
  logic [DW-1:0] expRes;
  logic          expOvf;
  logic [DW-1:0] mCtr;

  typedef struct {
    string         name;
    logic [2:0]    fs;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [7:0]    st;
    logic [DW-1:0] expRes;
    logic          expOvf;
  } vec_t;

  vec_t vecs[7];

  ula_seq #(.DATA_W(DW), .CTR_BYTES(CB)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .fs       (fs),
    .bus_a    (bus_a),
    .bus_b    (bus_b),
    .step     (step),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .bus_ula  (bus_ula),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  // Counter value as a number: byte 0 is the most significant digit
  function automatic logic [CW-1:0] getField(input logic [DW-1:0] blk);
    logic [CW-1:0] v;
    v = '0;
    for (int k = 0; k < CB; k++) v = (v << 8) | CW'(blk[8*k +: 8]);
    return v;
  endfunction

  function automatic logic [DW-1:0] setField(input logic [DW-1:0] blk, input logic [CW-1:0] val);
    logic [DW-1:0] r;
    logic [CW-1:0] v;
    r = blk;
    v = val;
    for (int k = CB - 1; k >= 0; k--) begin
      r[8*k +: 8] = v[7:0];
      v = v >> 8;
    end
    return r;
  endfunction

  // Apply one accepted operation to the model
  task automatic modelIssue(input logic [2:0] f, input logic [DW-1:0] a, input logic [DW-1:0] b,
                            input logic [7:0] st);
    logic [CW:0] s;
    expOvf = 1'b0;
    case (f)
      3'd0: expRes = a ^ b;
      3'd1: begin
        s      = {1'b0, getField(a)} + (CW+1)'(st);
        expRes = setField(a, s[CW-1:0]);
        expOvf = s[CW];
      end
      3'd3: begin
        expRes = a;
        mCtr   = a;
      end
      3'd4: begin
        expRes = mCtr;
        s      = {1'b0, getField(mCtr)} + (CW+1)'(1);
        mCtr   = setField(mCtr, s[CW-1:0]);
        expOvf = s[CW];
      end
      default: expRes = a;
    endcase
  endtask

  task automatic checkVal(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkOutput();
    checkVal("out_valid", DW'(out_valid), DW'(expValid));
    checkVal("bus_ula", bus_ula, expRes);
    checkVal("ovf", DW'(ovf), DW'(expOvf));
    checkVal("in_ready", DW'(in_ready), DW'(!expValid || out_ready));
  endtask

  // One clock cycle of stimulus; the model advances on the same edge as the DUT
  task automatic applyStimulus(input logic iv, input logic [2:0] f, input logic [DW-1:0] a,
                               input logic [DW-1:0] b, input logic [7:0] st, input logic ordy);
    logic acc;
    in_valid  = iv;
    fs        = f;
    bus_a     = a;
    bus_b     = b;
    step      = st;
    out_ready = ordy;
    #1;
    checkVal("in_ready_pre", DW'(in_ready), DW'(!expValid || ordy));
    acc = iv && (!expValid || ordy);
    if (acc) begin
      modelIssue(f, a, b, st);
      expValid = 1'b1;
    end else if (ordy) begin
      expValid = 1'b0;
    end
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic applyReset(input logic iv);
    rst       = 1'b1;
    in_valid  = iv;
    fs        = 3'd4;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    expValid = 1'b0;
    expRes   = '0;
    expOvf   = 1'b0;
    mCtr     = '0;
    checkOutput();
  endtask

  function automatic logic [DW-1:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [DW-1:0] held;
    logic [DW-1:0] ra;
    logic [2:0]    rf;

    vecs[0] = '{"inc_basic", 3'd1, 128'hFFFF_FFFF_FFFF_FFFF_0000_0000_0000_0000, '0, 8'd1,
                128'hFFFF_FFFF_FFFF_FFFF_0100_0000_0000_0000, 1'b0};
    vecs[1] = '{"inc_chain", 3'd1, 128'h1234_5678_9ABC_DEF0_FFFF_FFFF_FFFF_FF00, '0, 8'd1,
                128'h1234_5678_9ABC_DEF0_0000_0000_0000_0001, 1'b0};
    vecs[2] = '{"inc_wrap", 3'd1, 128'h1234_5678_9ABC_DEF0_FFFF_FFFF_FFFF_FFFF, '0, 8'd1,
                128'h1234_5678_9ABC_DEF0_0000_0000_0000_0000, 1'b1};
    vecs[3] = '{"inc_step_ff", 3'd1, 128'h0000_0000_0000_0000_0200_0000_0000_0000, '0, 8'hFF,
                128'h0000_0000_0000_0000_0101_0000_0000_0000, 1'b0};
    vecs[4] = '{"xor", 3'd0, {16{8'hA5}}, {16{8'h5A}}, 8'd0, {16{8'hFF}}, 1'b0};
    vecs[5] = '{"mov", 3'd2, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F1E_2D3C, 128'h77, 8'd9,
                128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F1E_2D3C, 1'b0};
    vecs[6] = '{"fs7", 3'd7, 128'hCAFE_F00D_0000_1111_2222_3333_4444_5555, 128'h99, 8'd3,
                128'hCAFE_F00D_0000_1111_2222_3333_4444_5555, 1'b0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    fs        = '0;
    bus_a     = '0;
    bus_b     = '0;
    step      = '0;
    out_ready = 1'b0;
    expValid  = 1'b0;
    expRes    = '0;
    expOvf    = 1'b0;
    mCtr      = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput();

    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b1, vecs[i].fs, vecs[i].a, vecs[i].b, vecs[i].st, 1'b1);
      checkVal({vecs[i].name, "_res"}, bus_ula, vecs[i].expRes);
      checkVal({vecs[i].name, "_ovf"}, DW'(ovf), DW'(vecs[i].expOvf));
    end
    applyStimulus(1'b0, 3'd0, '0, '0, 8'd0, 1'b1);
    checkVal("drain_keeps_bus", bus_ula, vecs[6].expRes);

    // LDC then back-to-back NXT
    applyStimulus(1'b1, 3'd3, '0, '0, 8'd0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 3'd4, '0, '0, 8'd0, 1'b1);
      checkVal($sformatf("nxt_seq%0d", i), DW'(bus_ula[63:56]), DW'(i));
    end

    // Backpressure: one accepted NXT, then three rejected ones
    applyStimulus(1'b0, 3'd0, '0, '0, 8'd0, 1'b1);
    applyStimulus(1'b1, 3'd4, '0, '0, 8'd0, 1'b0);
    checkVal("bp_first", DW'(bus_ula[63:56]), DW'(8'h04));
    held = bus_ula;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 3'd4, '0, '0, 8'd0, 1'b0);
      checkVal("bp_hold", bus_ula, held);
      checkVal("bp_in_ready", DW'(in_ready), '0);
    end
    applyStimulus(1'b1, 3'd4, '0, '0, 8'd0, 1'b1);
    checkVal("bp_next", DW'(bus_ula[63:56]), DW'(8'h05));

    // Reset with a held result and an in-flight request
    applyReset(1'b1);
    checkVal("rst_valid", DW'(out_valid), '0);
    checkVal("rst_bus", bus_ula, '0);
    applyStimulus(1'b1, 3'd4, '0, '0, 8'd0, 1'b1);
    checkVal("rst_nxt", bus_ula, '0);

    // Counter wrap, with MOV and fs=7 leaving the counter alone
    applyStimulus(1'b1, 3'd3, 128'hCAFE_0000_0000_BEEF_FFFF_FFFF_FFFF_FFFF, '0, 8'd0, 1'b1);
    applyStimulus(1'b1, 3'd4, '0, '0, 8'd0, 1'b1);
    checkVal("wrap_res", bus_ula, 128'hCAFE_0000_0000_BEEF_FFFF_FFFF_FFFF_FFFF);
    checkVal("wrap_ovf", DW'(ovf), DW'(1'b1));
    applyStimulus(1'b1, 3'd2, rand128(), rand128(), 8'd5, 1'b1);
    applyStimulus(1'b1, 3'd7, rand128(), rand128(), 8'd5, 1'b1);
    applyStimulus(1'b1, 3'd4, '0, '0, 8'd0, 1'b1);
    checkVal("wrap_after", bus_ula, 128'hCAFE_0000_0000_BEEF_0000_0000_0000_0000);
    checkVal("wrap_after_ovf", DW'(ovf), '0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 63) == 0) begin
        applyReset(1'($urandom_range(0, 1)));
      end else begin
        ra = rand128();
        if ($urandom_range(0, 2) == 0) ra[63:0] = {8'($urandom), 56'hFF_FFFF_FFFF_FFFF};
        rf = ($urandom_range(0, 2) == 0) ? 3'd4 : 3'($urandom_range(0, 7));
        applyStimulus(1'($urandom_range(0, 3) != 0), rf, ra, rand128(), 8'($urandom),
                      1'($urandom_range(0, 3) != 0));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
